booth_mult_seq: RTL

Parametrised sequential radix-2 Booth multiplier with valid/ready handshakes on both operand input and product output. Successor to the fixed 8-bit Booth multiplier top, which split FSM and datapath and had no backpressure. It generalises operand width and holds the product until the consumer accepts it. It sits between an operand producer and a result consumer inside the arithmetic unit.

---
 rtl/booth_pkg.sv | 32 +++
 rtl/booth_step.sv | 46 ++++
 rtl/booth_mult_seq.sv | 137 +++++++++++++
 3 files changed

// File: rtl/booth_pkg.sv
// rtl/booth_pkg.sv - shared types and Booth decode for the sequential Booth multiplier
//
// Contents:
//   booth_state_t : controller states IDLE/RUN/DONE (2-bit, value 3 unused)
//   booth_op_t    : per-step action NOP/ADD/SUB
//   booth_decode  : maps the {Q[0], Q-1} bit pair to the step action
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } booth_state_t;

    typedef enum logic [1:0] {
        NOP = 2'd0,
        ADD = 2'd1,
        SUB = 2'd2
    } booth_op_t;

    // 01: end of a run of ones -> add M; 10: start of a run of ones -> subtract M.
    function automatic booth_op_t booth_decode(input logic q0, input logic qm1);
        booth_op_t op;
        case ({q0, qm1})
            2'b01:   op = ADD;
            2'b10:   op = SUB;
            default: op = NOP;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/booth_step.sv
// rtl/booth_step.sv - one combinational radix-2 Booth iteration
//
// Parameters: NI - operand width seen by the iteration (ACC is NI+1 bits)
// Ports:
//   acc      in  NI+1  partial accumulator
//   q        in  NI    multiplier / low product bits
//   qm1      in  1     bit shifted out of q on the previous step
//   m        in  NI    multiplicand (two's complement)
//   acc_next out NI+1  accumulator after add/sub and arithmetic shift
//   q_next   out NI    q after shift
//   qm1_next out 1     new Q-1 (old q[0])
module booth_step
    import booth_pkg::*;
#(
    parameter int NI = 8
) (
    input  logic [NI:0]   acc,
    input  logic [NI-1:0] q,
    input  logic          qm1,
    input  logic [NI-1:0] m,
    output logic [NI:0]   acc_next,
    output logic [NI-1:0] q_next,
    output logic          qm1_next
);

    logic [NI:0] m_ext;
    logic [NI:0] sum;

    // One guard bit on ACC keeps ACC - (most negative M) representable.
    assign m_ext = {m[NI-1], m};

    always_comb begin
        sum = acc;
        case (booth_decode(q[0], qm1))
            ADD:     sum = acc + m_ext;
            SUB:     sum = acc - m_ext;
            default: sum = acc;
        endcase
    end

    // Arithmetic right shift of the concatenation {sum, q, qm1}.
    assign acc_next = {sum[NI], sum[NI:1]};
    assign q_next   = {sum[0], q[NI-1:1]};
    assign qm1_next = q[0];

endmodule

// File: rtl/booth_mult_seq.sv
// rtl/booth_mult_seq.sv - sequential radix-2 Booth multiplier with valid/ready on both sides
//
// Optional feature macro: BOOTH_UNSIGNED_EN (adds is_signed, runs WIDTH+1 steps)
// Parameters: WIDTH - operand width (>= 2); product is 2*WIDTH bits
// Ports:
//   clk       in  1        rising-edge clock
//   rst       in  1        asynchronous active-high reset
//   in_valid  in  1        operands valid
//   in_ready  out 1        idle, operands can be accepted
//   A         in  WIDTH    multiplicand
//   B         in  WIDTH    multiplier
//   is_signed in  1        (BOOTH_UNSIGNED_EN only) 1 = signed, 0 = unsigned operands
//   out_valid out 1        Y holds a finished product
//   out_ready in  1        consumer accepts Y
//   Y         out 2*WIDTH  registered product
//   state     out 2        current FSM state (debug)
module booth_mult_seq
    import booth_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
`ifdef BOOTH_UNSIGNED_EN
    input  logic               is_signed,
`endif
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] Y,
    output logic [1:0]         state
);

`ifdef BOOTH_UNSIGNED_EN
    localparam int NI = WIDTH + 1;
`else
    localparam int NI = WIDTH;
`endif
    localparam int CW = $clog2(NI + 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(NI);

    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_RUN  = RUN;
    localparam logic [1:0] S_DONE = DONE;

    logic [1:0]         state_q;
    logic [NI-1:0]      m_q;
    logic [NI-1:0]      q_q;
    logic [NI:0]        acc_q;
    logic               qm1_q;
    logic [CW-1:0]      cnt_q;
    logic [2*WIDTH-1:0] y_q;

    logic [NI-1:0]      a_ext;
    logic [NI-1:0]      b_ext;
    logic [NI:0]        acc_nx;
    logic [NI-1:0]      q_nx;
    logic               qm1_nx;
    logic [2*NI:0]      prod_full;
    logic               unused_prod_hi;

`ifdef BOOTH_UNSIGNED_EN
    // The extra top bit turns unsigned operands into non-negative signed ones.
    assign a_ext = {is_signed & A[WIDTH-1], A};
    assign b_ext = {is_signed & B[WIDTH-1], B};
`else
    assign a_ext = A;
    assign b_ext = B;
`endif

    booth_step #(
        .NI(NI)
    ) u_step (
        .acc      (acc_q),
        .q        (q_q),
        .qm1      (qm1_q),
        .m        (m_q),
        .acc_next (acc_nx),
        .q_next   (q_nx),
        .qm1_next (qm1_nx)
    );

    // Upper bits are pure sign extension for legal operands; only the low 2*WIDTH are kept.
    assign prod_full      = {acc_nx, q_nx};
    assign unused_prod_hi = ^prod_full[2*NI:2*WIDTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            m_q     <= '0;
            q_q     <= '0;
            acc_q   <= '0;
            qm1_q   <= 1'b0;
            cnt_q   <= '0;
            y_q     <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        m_q     <= a_ext;
                        q_q     <= b_ext;
                        acc_q   <= '0;
                        qm1_q   <= 1'b0;
                        cnt_q   <= CNT_INIT;
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    acc_q <= acc_nx;
                    q_q   <= q_nx;
                    qm1_q <= qm1_nx;
                    cnt_q <= cnt_q - CW'(1);
                    // Last step: capture the product straight from the step output.
                    if (cnt_q == CW'(1)) begin
                        y_q     <= prod_full[2*WIDTH-1:0];
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign Y         = y_q;
    assign state     = state_q;

endmodule
